// File: rtl/button_debounce.sv
// Push-button conditioner: synchronizer, debounce FSM and long-press hold timer.
// Define BUTTON_PRESS_COUNT_EN to build the 8-bit accepted-press counter.
module button_debounce #(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 150000,
    parameter int LONG_CYCLES     = 15000000,
    parameter int ACTIVE_LOW      = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       btn_in,
    output logic       btn_level,
    output logic       press_pulse,
    output logic       release_pulse,
    output logic       long_pulse,
    output logic [7:0] press_count
);

    localparam int SS = (SYNC_STAGES < 2) ? 2 :
                        (SYNC_STAGES > 4) ? 4 : SYNC_STAGES;
    localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int HW = (LONG_CYCLES > 0) ? $clog2(LONG_CYCLES + 1) : 1;

    localparam logic [DW-1:0] DEB_LAST  = DW'(DEBOUNCE_CYCLES - 1);
    localparam logic [HW-1:0] LONG_MAX  = HW'(LONG_CYCLES);
    localparam logic [HW-1:0] LONG_LAST =
        HW'((LONG_CYCLES > 0) ? LONG_CYCLES - 1 : 0);
    localparam logic          IDLE_PIN  = (ACTIVE_LOW != 0);
    localparam logic          LONG_EN   = (LONG_CYCLES != 0);
    localparam logic          DEB_ONE   = (DEBOUNCE_CYCLES == 1);

    typedef enum logic [1:0] {
        RELEASED,
        PRESS_WAIT,
        PRESSED,
        RELEASE_WAIT
    } state_t;

    logic [SS-1:0] r_sync;
    state_t        r_state;
    logic [DW-1:0] r_stab;
    logic [HW-1:0] r_hold;
    logic          w_s;
    logic          w_long_hit;
    logic          w_hold_run;

    // Reset loads the released level so a held button reads as a new press.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_sync <= {SS{IDLE_PIN}};
        end else begin
            r_sync <= {r_sync[SS-2:0], btn_in};
        end
    end

    assign w_s        = r_sync[SS-1] ^ IDLE_PIN;
    assign w_hold_run = (r_hold != LONG_MAX);
    assign w_long_hit = LONG_EN && (r_hold == LONG_LAST);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state       <= RELEASED;
            r_stab        <= '0;
            r_hold        <= '0;
            btn_level     <= 1'b0;
            press_pulse   <= 1'b0;
            release_pulse <= 1'b0;
            long_pulse    <= 1'b0;
        end else begin
            press_pulse   <= 1'b0;
            release_pulse <= 1'b0;
            long_pulse    <= 1'b0;
            unique case (r_state)
                RELEASED: begin
                    if (w_s) begin
                        if (DEB_ONE) begin
                            r_state     <= PRESSED;
                            r_stab      <= '0;
                            r_hold      <= '0;
                            btn_level   <= 1'b1;
                            press_pulse <= 1'b1;
                        end else begin
                            r_state <= PRESS_WAIT;
                            r_stab  <= DW'(1);
                        end
                    end
                end
                PRESS_WAIT: begin
                    if (!w_s) begin
                        r_state <= RELEASED;
                        r_stab  <= '0;
                    end else if (r_stab == DEB_LAST) begin
                        r_state     <= PRESSED;
                        r_stab      <= '0;
                        r_hold      <= '0;
                        btn_level   <= 1'b1;
                        press_pulse <= 1'b1;
                    end else begin
                        r_stab <= r_stab + 1'b1;
                    end
                end
                PRESSED: begin
                    if (!w_s && DEB_ONE) begin
                        r_state       <= RELEASED;
                        btn_level     <= 1'b0;
                        release_pulse <= 1'b1;
                    end else begin
                        if (w_hold_run) r_hold <= r_hold + 1'b1;
                        if (w_long_hit) long_pulse <= 1'b1;
                        if (!w_s) begin
                            r_state <= RELEASE_WAIT;
                            r_stab  <= DW'(1);
                        end
                    end
                end
                RELEASE_WAIT: begin
                    // A long-press landing on the release edge is dropped.
                    if (!w_s && (r_stab == DEB_LAST)) begin
                        r_state       <= RELEASED;
                        r_stab        <= '0;
                        btn_level     <= 1'b0;
                        release_pulse <= 1'b1;
                    end else begin
                        if (w_hold_run) r_hold <= r_hold + 1'b1;
                        if (w_long_hit) long_pulse <= 1'b1;
                        if (w_s) begin
                            r_state <= PRESSED;
                            r_stab  <= '0;
                        end else begin
                            r_stab <= r_stab + 1'b1;
                        end
                    end
                end
                default: begin
                    r_state <= RELEASED;
                    r_stab  <= '0;
                end
            endcase
        end
    end

`ifdef BUTTON_PRESS_COUNT_EN
    logic [7:0] r_count;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_count <= 8'h00;
        end else if (press_pulse) begin
            r_count <= r_count + 8'h01;
        end
    end

    assign press_count = r_count;
`else
    assign press_count = 8'h00;
`endif

endmodule

// File: tb/tb_button_debounce.sv
// Directed bench for button_debounce (SYNC=2, DEBOUNCE=4, LONG=20, active-low).
module tb_button_debounce;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       btn_in = 1'b1;
    logic       btn_level;
    logic       press_pulse;
    logic       release_pulse;
    logic       long_pulse;
    logic [7:0] press_count;

    int checks = 0;
    int failures = 0;

`ifdef BUTTON_PRESS_COUNT_EN
    localparam logic [7:0] CNT_AFTER_MID = 8'd1;
    localparam logic [7:0] CNT_FINAL     = 8'd1;
`else
    localparam logic [7:0] CNT_AFTER_MID = 8'd0;
    localparam logic [7:0] CNT_FINAL     = 8'd0;
`endif

    button_debounce #(
        .SYNC_STAGES(2),
        .DEBOUNCE_CYCLES(4),
        .LONG_CYCLES(20),
        .ACTIVE_LOW(1)
    ) dut (
        .clk(clk),
        .rst(rst),
        .btn_in(btn_in),
        .btn_level(btn_level),
        .press_pulse(press_pulse),
        .release_pulse(release_pulse),
        .long_pulse(long_pulse),
        .press_count(press_count)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        logic [11:0] got;
        rst = 1'b0;
        btn_in = 1'b1;
        #2;
        got = {btn_level, press_pulse, release_pulse, long_pulse, press_count};
        checks++;
        if (got !== 12'h000) begin
            failures++;
            $display("FAIL reset_initial: got %0h expected 0", got);
        end
        repeat (3) tick();
        got = {btn_level, press_pulse, release_pulse, long_pulse, press_count};
        checks++;
        if (got !== 12'h000) begin
            failures++;
            $display("FAIL reset_held: got %0h expected 0", got);
        end
        rst = 1'b1;
        repeat (4) tick();
        got = {btn_level, press_pulse, release_pulse, long_pulse, press_count};
        checks++;
        if (got !== 12'h000) begin
            failures++;
            $display("FAIL reset_idle: got %0h expected 0", got);
        end
    endtask

    task automatic test_glitch();
        logic [2:0] got;
        btn_in = 1'b0;
        repeat (3) tick();
        btn_in = 1'b1;
        for (int i = 1; i <= 10; i++) begin
            tick();
            got = {btn_level, press_pulse, release_pulse};
            checks++;
            if (got !== 3'b000) begin
                failures++;
                $display("FAIL glitch t=%0d: got %b expected 000", i, got);
            end
        end
    endtask

    task automatic test_press();
        btn_in = 1'b0;
        for (int i = 1; i <= 8; i++) begin
            tick();
            checks++;
            if (press_pulse !== (i == 6)) begin
                failures++;
                $display("FAIL press_pulse t=%0d: got %b expected %b",
                         i, press_pulse, (i == 6));
            end
            checks++;
            if (btn_level !== (i >= 6)) begin
                failures++;
                $display("FAIL press_level t=%0d: got %b expected %b",
                         i, btn_level, (i >= 6));
            end
            checks++;
            if ({release_pulse, long_pulse} !== 2'b00) begin
                failures++;
                $display("FAIL press_other t=%0d: got %b expected 00",
                         i, {release_pulse, long_pulse});
            end
        end
    endtask

    task automatic test_long();
        int nlong = 0;
        for (int i = 9; i <= 46; i++) begin
            tick();
            if (long_pulse === 1'b1) nlong++;
            checks++;
            if (long_pulse !== (i == 26)) begin
                failures++;
                $display("FAIL long_pulse t=%0d: got %b expected %b",
                         i, long_pulse, (i == 26));
            end
            checks++;
            if ({press_pulse, release_pulse, btn_level} !== 3'b001) begin
                failures++;
                $display("FAIL long_other t=%0d: got %b expected 001",
                         i, {press_pulse, release_pulse, btn_level});
            end
        end
        checks++;
        if (nlong != 1) begin
            failures++;
            $display("FAIL long_once: got %0d expected 1", nlong);
        end
    endtask

    task automatic test_release_bounce();
        btn_in = 1'b1;
        repeat (2) tick();
        btn_in = 1'b0;
        for (int i = 1; i <= 10; i++) begin
            tick();
            checks++;
            if ({btn_level, release_pulse, long_pulse} !== 3'b100) begin
                failures++;
                $display("FAIL bounce t=%0d: got %b expected 100",
                         i, {btn_level, release_pulse, long_pulse});
            end
        end
        btn_in = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            tick();
            checks++;
            if (release_pulse !== (i == 6)) begin
                failures++;
                $display("FAIL release_pulse t=%0d: got %b expected %b",
                         i, release_pulse, (i == 6));
            end
            checks++;
            if (btn_level !== (i < 6)) begin
                failures++;
                $display("FAIL release_level t=%0d: got %b expected %b",
                         i, btn_level, (i < 6));
            end
        end
    endtask

    task automatic test_reset_mid();
        logic [3:0] got;
        btn_in = 1'b0;
        repeat (8) tick();
        checks++;
        if (btn_level !== 1'b1) begin
            failures++;
            $display("FAIL mid_pressed: got %b expected 1", btn_level);
        end
        @(posedge clk);
        #3;
        rst = 1'b0;
        #1;
        got = {btn_level, press_pulse, release_pulse, long_pulse};
        checks++;
        if (got !== 4'b0000) begin
            failures++;
            $display("FAIL mid_async: got %b expected 0000", got);
        end
        repeat (2) tick();
        got = {btn_level, press_pulse, release_pulse, long_pulse};
        checks++;
        if (got !== 4'b0000) begin
            failures++;
            $display("FAIL mid_in_reset: got %b expected 0000", got);
        end
        rst = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            tick();
            checks++;
            if (press_pulse !== (i == 6)) begin
                failures++;
                $display("FAIL mid_repress t=%0d: got %b expected %b",
                         i, press_pulse, (i == 6));
            end
            checks++;
            if (release_pulse !== 1'b0) begin
                failures++;
                $display("FAIL mid_no_release t=%0d: got %b expected 0",
                         i, release_pulse);
            end
        end
        checks++;
        if (press_count !== CNT_AFTER_MID) begin
            failures++;
            $display("FAIL mid_count: got %0d expected %0d",
                     press_count, CNT_AFTER_MID);
        end
    endtask

    task automatic test_count();
        int npress = 0;
        btn_in = 1'b1;
        repeat (8) tick();
        for (int k = 0; k < 256; k++) begin
            btn_in = 1'b0;
            for (int j = 0; j < 7; j++) begin
                tick();
                if (press_pulse === 1'b1) npress++;
            end
            btn_in = 1'b1;
            repeat (7) tick();
        end
        repeat (2) tick();
        checks++;
        if (npress != 256) begin
            failures++;
            $display("FAIL count_pulses: got %0d expected 256", npress);
        end
        checks++;
        if (press_count !== CNT_FINAL) begin
            failures++;
            $display("FAIL count_wrap: got %0d expected %0d",
                     press_count, CNT_FINAL);
        end
    endtask

    initial begin
        test_reset();
        test_glitch();
        test_press();
        test_long();
        test_release_bounce();
        test_reset_mid();
        test_count();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
